// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - boot loader from UART bytes into instruction memory
// Define UART_IMEM_LOADER_CHECKSUM_EN to accumulate a running sum of written words.
module uart_imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int LOAD_WORDS  = 32,
  parameter int IDLE_CYCLES = 208334
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  IDLE_MAX   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(LOAD_WORDS);
  localparam logic [ADDR_W:0]   WC_ONE     = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [23:0]      shift_reg;
  logic [CNT_W-1:0] idle_cnt;
  logic [31:0]      next_word;
  logic             timeout;
  logic             last_write;
  logic             word_write;

  // The 4th byte goes straight into the write data, so only three bytes are buffered.
  assign next_word  = {uart_rx_data, shift_reg};
  assign timeout    = (idle_cnt == IDLE_MAX);
  assign last_write = imem_we && (word_count == LAST_COUNT);
  assign word_write = (state == ST_LOAD) && !last_write && !uart_rx_break &&
                      uart_rx_valid && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      byte_idx   <= 2'd0;
      shift_reg  <= 24'h0;
      idle_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (uart_rx_valid && !uart_rx_break) begin
            shift_reg[7:0] <= uart_rx_data;
            byte_idx       <= 2'd1;
            idle_cnt       <= '0;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Saturating so a break landing on the timeout cycle only defers the timeout.
          if (uart_rx_valid)
            idle_cnt <= '0;
          else if (!timeout)
            idle_cnt <= idle_cnt + CNT_ONE;

          if (last_write) begin
            state      <= ST_RUN;
            load_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end else if (uart_rx_break) begin
            if (byte_idx != 2'd0)
              load_err <= 1'b1;
            byte_idx <= 2'd0;
          end else if (uart_rx_valid) begin
            case (byte_idx)
              2'd0:    shift_reg[7:0]   <= uart_rx_data;
              2'd1:    shift_reg[15:8]  <= uart_rx_data;
              2'd2:    shift_reg[23:16] <= uart_rx_data;
              default: ;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (word_write) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_count[ADDR_W-1:0];
              imem_wdata <= next_word;
              word_count <= word_count + WC_ONE;
              if (timeout) begin
                state      <= ST_RUN;
                load_done  <= 1'b1;
                core_rst_n <= 1'b1;
              end
            end
          end else if (timeout) begin
            if (byte_idx != 2'd0)
              load_err <= 1'b1;
            byte_idx   <= 2'd0;
            state      <= ST_RUN;
            load_done  <= 1'b1;
            core_rst_n <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      checksum <= 32'h0;
    else if (word_write)
      checksum <= checksum + next_word;
  end
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - bench for uart_imem_loader (LOAD_WORDS 32 and 2 side by side)
module tb_uart_imem_loader;

  localparam int IDLE = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h0;
  logic       rx_break = 1'b0;

  logic        imem_we    [2];
  logic [7:0]  imem_addr  [2];
  logic [31:0] imem_wdata [2];
  logic        core_rst_n [2];
  logic        load_done  [2];
  logic        load_err   [2];
  logic [8:0]  word_count [2];
  logic [31:0] checksum   [2];

  int n_checks = 0;
  int n_errs   = 0;

  int LW [2] = '{32, 2};

  int          m_nb [2];
  logic [31:0] m_part [2];
  logic [31:0] m_sum [2];
  int          m_wc [2];
  int          m_quiet [2];
  bit          m_load [2];
  bit          m_fin [2];
  bit          m_done [2];
  bit          m_err [2];
  bit          e_we [2];
  logic [7:0]  e_addr [2];
  logic [31:0] e_data [2];

  logic [31:0] prog [21] = '{
    32'hfe010113, 32'h00812e23, 32'h02010413, 32'h00500793, 32'hfef42623,
    32'h00a00793, 32'hfef42423, 32'hfec42703, 32'hfe842783, 32'h00f707b3,
    32'hfef42223, 32'hfe442783, 32'h00178793, 32'hfef42223, 32'h00000013,
    32'h00000013, 32'hfe442783, 32'h00078513, 32'h01c12403, 32'h02010113,
    32'h00008067};

  uart_imem_loader #(.ADDR_W(8), .LOAD_WORDS(32), .IDLE_CYCLES(IDLE)) dut0 (
    .clk(clk), .resetn(resetn), .uart_rx_valid(rx_valid), .uart_rx_data(rx_data),
    .uart_rx_break(rx_break), .imem_we(imem_we[0]), .imem_addr(imem_addr[0]),
    .imem_wdata(imem_wdata[0]), .core_rst_n(core_rst_n[0]), .load_done(load_done[0]),
    .load_err(load_err[0]), .word_count(word_count[0]), .checksum(checksum[0]));

  uart_imem_loader #(.ADDR_W(8), .LOAD_WORDS(2), .IDLE_CYCLES(IDLE)) dut1 (
    .clk(clk), .resetn(resetn), .uart_rx_valid(rx_valid), .uart_rx_data(rx_data),
    .uart_rx_break(rx_break), .imem_we(imem_we[1]), .imem_addr(imem_addr[1]),
    .imem_wdata(imem_wdata[1]), .core_rst_n(core_rst_n[1]), .load_done(load_done[1]),
    .load_err(load_err[1]), .word_count(word_count[1]), .checksum(checksum[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset(input int i);
    m_nb[i] = 0; m_part[i] = 0; m_sum[i] = 0; m_wc[i] = 0; m_quiet[i] = 0;
    m_load[i] = 0; m_fin[i] = 0; m_done[i] = 0; m_err[i] = 0;
    e_we[i] = 0; e_addr[i] = 0; e_data[i] = 0;
  endtask

  // Expected effect of the inputs present at the clock edge just taken.
  task automatic m_step(input int i);
    bit to;
    e_we[i] = 0;
    if (m_done[i]) return;
    if (m_fin[i]) begin
      m_done[i] = 1;
      return;
    end
    to = m_load[i] && (m_quiet[i] >= IDLE);
    if (rx_break) begin
      if (m_nb[i] != 0) m_err[i] = 1;
      m_nb[i] = 0; m_part[i] = 0;
    end else if (rx_valid) begin
      m_part[i] = m_part[i] | (32'(rx_data) << (8 * m_nb[i]));
      m_nb[i]++;
      if (m_nb[i] == 4) begin
        e_we[i] = 1; e_addr[i] = 8'(m_wc[i]); e_data[i] = m_part[i];
        m_wc[i]++; m_sum[i] = m_sum[i] + m_part[i];
        m_part[i] = 0; m_nb[i] = 0;
        if (m_wc[i] == LW[i]) m_fin[i] = 1;
        if (to) m_done[i] = 1;
      end
    end else if (to) begin
      if (m_nb[i] != 0) m_err[i] = 1;
      m_nb[i] = 0; m_part[i] = 0; m_done[i] = 1;
    end
    if (m_load[i]) m_quiet[i] = rx_valid ? 0 : m_quiet[i] + 1;
    if (rx_valid && !rx_break) m_load[i] = 1;
  endtask

  task automatic chk_dut(input int i);
    logic [31:0] exp_cs;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    exp_cs = m_sum[i];
`else
    exp_cs = 32'h0;
`endif
    chk($sformatf("d%0d_we", i), 32'(imem_we[i]), 32'(e_we[i]));
    chk($sformatf("d%0d_addr", i), 32'(imem_addr[i]), 32'(e_addr[i]));
    chk($sformatf("d%0d_wdata", i), imem_wdata[i], e_data[i]);
    chk($sformatf("d%0d_wc", i), 32'(word_count[i]), 32'(m_wc[i]));
    chk($sformatf("d%0d_done", i), 32'(load_done[i]), 32'(m_done[i]));
    chk($sformatf("d%0d_core_rst_n", i), 32'(core_rst_n[i]), 32'(m_done[i]));
    chk($sformatf("d%0d_err", i), 32'(load_err[i]), 32'(m_err[i]));
    chk($sformatf("d%0d_checksum", i), checksum[i], exp_cs);
  endtask

  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) m_reset(i);
      else m_step(i);
      chk_dut(i);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic b);
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_break = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) cyc(1'b1, w[8*k +: 8], 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0; rx_break = 1'b0; rx_data = 8'h0;
    resetn = 1'b0;
    #1;
    chk("rst_core0", 32'(core_rst_n[0]), 32'h0);
    chk("rst_core1", 32'(core_rst_n[1]), 32'h0);
    chk("rst_wc0", 32'(word_count[0]), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_cs3;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    exp_cs3 = 32'h3;
`else
    exp_cs3 = 32'h0;
`endif

    // First word and a 21-word program ended by line idle
    do_reset();
    chk("reset_done", 32'(load_done[0]), 32'h0);
    chk("reset_err", 32'(load_err[0]), 32'h0);
    send_word(prog[0]);
    after_edge();
    chk("w0_we", 32'(imem_we[0]), 32'h1);
    chk("w0_addr", 32'(imem_addr[0]), 32'h0);
    chk("w0_data", imem_wdata[0], 32'hfe010113);
    chk("w0_wc", 32'(word_count[0]), 32'h1);
    for (int w = 1; w < 21; w++) begin
      send_word(prog[w]);
      idle(1);
    end
    idle(25);
    chk("prog_wc", 32'(word_count[0]), 32'd21);
    chk("prog_done", 32'(load_done[0]), 32'h1);
    chk("prog_core", 32'(core_rst_n[0]), 32'h1);
    chk("prog_err", 32'(load_err[0]), 32'h0);
    chk("prog_last", imem_wdata[0], 32'h00008067);
    chk("lw2_wc", 32'(word_count[1]), 32'd2);

    // Two-word limit: release the edge after the 2nd write, later words ignored
    do_reset();
    send_word(32'h00500793);
    idle(1);
    send_word(32'h00a00793);
    after_edge();
    chk("lw2_we", 32'(imem_we[1]), 32'h1);
    chk("lw2_addr", 32'(imem_addr[1]), 32'h1);
    chk("lw2_core_early", 32'(core_rst_n[1]), 32'h0);
    idle(1);
    after_edge();
    chk("lw2_core", 32'(core_rst_n[1]), 32'h1);
    send_word(32'h12345678);
    idle(3);
    chk("lw2_wc_after", 32'(word_count[1]), 32'd2);

    // Break discards a partial word
    do_reset();
    cyc(1'b1, 8'h93, 1'b0);
    cyc(1'b1, 8'h07, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'h00ff6f33);
    after_edge();
    chk("brk_err", 32'(load_err[0]), 32'h1);
    chk("brk_data", imem_wdata[0], 32'h00ff6f33);
    chk("brk_addr", 32'(imem_addr[0]), 32'h0);

    // Byte in the write cycle starts the next word
    do_reset();
    send_word(32'h11223344);
    send_word(32'h55667788);
    after_edge();
    chk("b2b_addr", 32'(imem_addr[0]), 32'h1);
    chk("b2b_data", imem_wdata[0], 32'h55667788);
    idle(2);

    // Reset in the middle of a load
    do_reset();
    send_word(32'h1);
    idle(1);
    send_word(32'h2);
    idle(2);
    chk("cs_12", checksum[0], exp_cs3);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    do_reset();
    send_word(32'hcafef00d);
    after_edge();
    chk("rl_addr", 32'(imem_addr[0]), 32'h0);
    chk("rl_data", imem_wdata[0], 32'hcafef00d);
    chk("rl_wc", 32'(word_count[0]), 32'h1);
    idle(2);

    // Break together with a byte, in IDLE and in LOAD
    do_reset();
    cyc(1'b1, 8'haa, 1'b1);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b1);
    send_word(32'h44332211);
    idle(2);
    chk("bv_err", 32'(load_err[0]), 32'h1);
    chk("bv_data", imem_wdata[0], 32'h44332211);

    // Timeout with a partial word pending
    do_reset();
    send_word(32'h0badf00d);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    idle(25);
    chk("to_err", 32'(load_err[0]), 32'h1);
    chk("to_done", 32'(load_done[0]), 32'h1);
    chk("to_wc", 32'(word_count[0]), 32'h1);

    // 4th byte on the timeout cycle: word written, then run
    do_reset();
    cyc(1'b1, 8'h0d, 1'b0);
    cyc(1'b1, 8'hf0, 1'b0);
    cyc(1'b1, 8'had, 1'b0);
    idle(IDLE);
    cyc(1'b1, 8'hde, 1'b0);
    after_edge();
    chk("tob_we", 32'(imem_we[0]), 32'h1);
    chk("tob_data", imem_wdata[0], 32'hdeadf00d);
    chk("tob_done", 32'(load_done[0]), 32'h1);
    chk("tob_err", 32'(load_err[0]), 32'h0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
